cv32e40p_ex_wb_pipeline: RTL
============================

CV32E40P_EX_WB_PIPELINE -- requirements
Module: cv32e40p_EX_WB_pipeline

Interface
REQ-001 SHALL: clk  in  1  gated core clock; one clock domain, all state on posedge clk.
REQ-002 SHALL: rst_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL: data_req_ex_i  in  1  EX issues LSU request.
REQ-004 SHALL: data_gnt_i  in  1  LSU grant; a request is accepted when data_req_ex_i && data_gnt_i.
REQ-005 SHALL: data_we_ex_i  in  1  request is a store (no writeback).
REQ-006 SHALL: regfile_we_ex_i  in  1  load targets the register file.
REQ-007 SHALL: regfile_waddr_ex_i  in  6  load destination address.
REQ-008 SHALL: data_misaligned_first_i  in  1  accepted request is the first half of a misaligned pair.
REQ-009 SHALL: lsu_rvalid_i  in  1  LSU response valid.
REQ-010 SHALL: lsu_rdata_i  in  32  LSU response data, already aligned and sign-extended.
REQ-011 SHALL: ex_ready_o  out  1  EX may issue a new LSU request.
REQ-012 SHALL: regfile_we_wb_o  out  1  WB write enable, one-cycle pulse.
REQ-013 SHALL: regfile_waddr_wb_o  out  6  WB write address.
REQ-014 SHALL: regfile_wdata_wb_o  out  32  WB write data.
REQ-015 SHALL: outstanding_o  out  2  number of outstanding loads (0..2).
REQ-016 SHALL: parity_err_o  out  1  registered parity mismatch flag.

Function
REQ-017 SHALL: hold a 2-entry in-order tracker; each entry is {we, waddr[5:0]}; write/read pointers are 1 bit and wrap 1->0.
REQ-018 SHALL: push on an accepted request with data_we_ex_i=0; pushed we = regfile_we_ex_i && !data_misaligned_first_i.
REQ-019 SHALL: never push on accepted stores; stores produce no entry and do not wait for writeback.
REQ-020 SHALL: pop one entry on lsu_rvalid_i when the tracker is non-empty.
REQ-021 SHALL: on lsu_rvalid_i with an empty tracker, ignore the response; no pop, no write.
REQ-022 SHALL: on simultaneous push and pop, perform both in the same cycle; count is unchanged.
REQ-023 SHALL: states EMPTY (count 0), ONE (count 1) and FULL (count 2); transitions follow push/pop; outstanding_o equals count.
REQ-024 SHALL: ex_ready_o = !FULL || lsu_rvalid_i, combinational; in FULL with no response, a grant SHALL NOT push (overflow guard).
REQ-025 SHALL: one cycle after a pop of an entry with we=1, assert regfile_we_wb_o for exactly one cycle; regfile_waddr_wb_o is the entry waddr and regfile_wdata_wb_o is lsu_rdata_i from the pop cycle.
REQ-026 SHALL: on a pop of an entry with we=0, keep regfile_we_wb_o low; address and data registers hold their previous values.
REQ-027 SHALL: latency from lsu_rvalid_i to regfile_we_wb_o is exactly 1 cycle; back-to-back responses give back-to-back write pulses.

Reset
REQ-028 SHALL: asynchronous rst_n low clears count, both pointers, entry contents, regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o and parity_err_o to 0.
REQ-029 SHALL: reset asserted while loads are outstanding discards those loads; any response after reset release is handled per REQ-021.

Configuration
REQ-030 SHALL: macro FT_WB_PARITY_EN defined -> each entry stores an even-parity bit over {we, waddr}, computed at push and checked at pop.
REQ-031 SHALL: with FT_WB_PARITY_EN, a mismatch sets parity_err_o high one cycle after the pop, coincident with the write slot, for one cycle.
REQ-032 SHALL: with FT_WB_PARITY_EN, a mismatch on a we=1 entry suppresses regfile_we_wb_o.
REQ-033 SHALL: without FT_WB_PARITY_EN, no parity storage exists and parity_err_o is tied 0.

Verification
REQ-034 SHALL: single load waddr=5: grant at T, rvalid rdata=0xDEADBEEF at T+3 -> at T+4 we_wb=1, waddr=5, wdata=0xDEADBEEF; outstanding 1->0.
REQ-035 SHALL: two loads waddr 3 and 7 granted back-to-back, no rvalid -> outstanding=2, ex_ready_o=0; then rvalid 0x11 and 0x22 on consecutive cycles -> writes to 3 then 7 on consecutive cycles.
REQ-036 SHALL: FULL with rvalid and a new grant in the same cycle -> one push and one pop, outstanding stays 2, correct in-order write sequence across pointer wrap.
REQ-037 SHALL: misaligned load waddr=9: first-half response -> no write; second-half response 0xCAFE0000 -> write to 9.
REQ-038 SHALL: store grant followed by rvalid -> no entry pushed, no write, outstanding=0; rst_n low with 2 outstanding -> all outputs 0 and a later rvalid is ignored.
REQ-039 SHALL: with FT_WB_PARITY_EN, force a bit flip in a stored waddr -> parity_err_o=1 one cycle after the pop and regfile_we_wb_o stays 0.

Source files
------------

// File: rtl/cv32e40p_ex_wb_pipeline.sv
// ============================================================================
// cv32e40p_ex_wb_pipeline
//
// Tracks loads issued by EX to the LSU and writes their responses back to
// the register file. A 2-entry in-order tracker holds {we, waddr} for each
// outstanding load. Responses pop the oldest entry. One cycle after the pop,
// a single-cycle write pulse carries the response data.
//
// Optional feature (macro FT_WB_PARITY_EN):
//   Each entry also stores an even-parity bit over {we, waddr}. The bit is
//   computed at push and checked at pop. On a mismatch, parity_err_o pulses
//   in the write slot and the write is suppressed. When the macro is not
//   defined, no parity bit is stored and parity_err_o is tied to 0.
//
// Ports:
//   clk                      in   gated core clock
//   rst_n                    in   asynchronous active-low reset
//   data_req_ex_i            in   EX issues an LSU request
//   data_gnt_i               in   LSU grant (accept = req && gnt)
//   data_we_ex_i             in   request is a store (no writeback)
//   regfile_we_ex_i          in   load targets the register file
//   regfile_waddr_ex_i[5:0]  in   load destination address
//   data_misaligned_first_i  in   accepted request is first half of a pair
//   lsu_rvalid_i             in   LSU response valid
//   lsu_rdata_i[31:0]        in   LSU response data (aligned, extended)
//   ex_ready_o               out  EX may issue a new LSU request
//   regfile_we_wb_o          out  WB write enable (one-cycle pulse)
//   regfile_waddr_wb_o[5:0]  out  WB write address
//   regfile_wdata_wb_o[31:0] out  WB write data
//   outstanding_o[1:0]       out  number of outstanding loads (0..2)
//   parity_err_o             out  registered parity mismatch flag
// ============================================================================
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no loads outstanding
// ONE   | one load outstanding
// FULL  | two loads outstanding; new loads only if a response pops this cycle

module cv32e40p_ex_wb_pipeline (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_ex_i,
    input  logic        data_gnt_i,
    input  logic        data_we_ex_i,
    input  logic        regfile_we_ex_i,
    input  logic [5:0]  regfile_waddr_ex_i,
    input  logic        data_misaligned_first_i,
    input  logic        lsu_rvalid_i,
    input  logic [31:0] lsu_rdata_i,
    output logic        ex_ready_o,
    output logic        regfile_we_wb_o,
    output logic [5:0]  regfile_waddr_wb_o,
    output logic [31:0] regfile_wdata_wb_o,
    output logic [1:0]  outstanding_o,
    output logic        parity_err_o
);

    // State encoding equals the outstanding-load count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       wptr_q, rptr_q;
    logic [6:0] entry_q [2];   // {we, waddr}

    logic       accept;
    logic       push, pop;
    logic [6:0] push_entry;
    logic [6:0] pop_entry;
    logic       pop_err;

    assign accept     = data_req_ex_i && data_gnt_i;
    // The first half of a misaligned load returns partial data, so its entry
    // is tracked but never written back.
    assign push_entry = {regfile_we_ex_i && !data_misaligned_first_i, regfile_waddr_ex_i};

    // Overflow guard: in FULL, a grant can push only when a response frees a
    // slot in the same cycle.
    assign push = accept && !data_we_ex_i && ((state_q != FULL) || lsu_rvalid_i);
    // A response that arrives with nothing tracked is dropped.
    assign pop  = lsu_rvalid_i && (state_q != EMPTY);

    assign pop_entry  = entry_q[rptr_q];
    assign ex_ready_o = (state_q != FULL) || lsu_rvalid_i;
    assign outstanding_o = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:    if (pop && !push) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // In FULL with push and pop together, both pointers address the same
    // slot. The pop reads the old contents before the push overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) entry_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                entry_q[wptr_q] <= push_entry;
                wptr_q          <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
        end
    end

`ifdef FT_WB_PARITY_EN
    logic par_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) par_q[i] <= 1'b0;
        end else if (push) begin
            par_q[wptr_q] <= ^push_entry;
        end
    end

    assign pop_err = pop && (par_q[rptr_q] != ^pop_entry);
`else
    assign pop_err = 1'b0;
`endif

    // Address and data load only on a real write. A pop of an entry with
    // we=0 leaves the previous values visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regfile_we_wb_o    <= 1'b0;
            regfile_waddr_wb_o <= '0;
            regfile_wdata_wb_o <= '0;
            parity_err_o       <= 1'b0;
        end else begin
            regfile_we_wb_o <= pop && pop_entry[6] && !pop_err;
            parity_err_o    <= pop_err;
            if (pop && pop_entry[6] && !pop_err) begin
                regfile_waddr_wb_o <= pop_entry[5:0];
                regfile_wdata_wb_o <= lsu_rdata_i;
            end
        end
    end

endmodule
